decade_emitter: RTL

- Drive side of the decade counter interface: converts a binary digit 0..9 into a clear pulse followed by exactly that many advance pulses, as seen on the decade counter's i_clear/i_advance inputs.
- Keeps an internal 5-bit Johnson-coded shadow of the expected counter state.
- Optionally compares the shadow against the counter's 5-bit output once the pulse train ends.
- Used wherever control logic must preset a decade counter, e.g. reloading a count before a status or byte-count sequence.

---
 rtl/decade_emitter_if.sv | 23 ++
 rtl/decade_emitter.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/decade_emitter_if.sv
// rtl/decade_emitter_if.sv - request and counter-strobe bundle for decade_emitter
interface decade_emitter_if;
  logic       i_start;
  logic [3:0] i_digit;
  logic [4:0] i_count;
  logic       o_clear;
  logic       o_advance;
  logic       o_busy;
  logic       o_done;
  logic [4:0] o_shadow;
  logic       o_digit_err;
  logic       o_check;

  modport master (
    output i_start, i_digit, i_count,
    input  o_clear, o_advance, o_busy, o_done, o_shadow, o_digit_err, o_check
  );

  modport slave (
    input  i_start, i_digit, i_count,
    output o_clear, o_advance, o_busy, o_done, o_shadow, o_digit_err, o_check
  );
endinterface

// File: rtl/decade_emitter.sv
// rtl/decade_emitter.sv - clear + N advance pulse train with Johnson shadow; optional DECADE_EMITTER_CHECK_EN
module decade_emitter #(
  parameter int CLR_W = 1,
  parameter int ADV_W = 2,
  parameter int GAP   = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  decade_emitter_if.slave  io_bus
);

  localparam int MAXW  = (CLR_W > ADV_W) ? ((CLR_W > GAP) ? CLR_W : GAP)
                                         : ((ADV_W > GAP) ? ADV_W : GAP);
  localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_SETTLE, S_PULSE, S_GAP, S_CHECK, S_DONE
  } state_t;

  state_t           r_state, w_next_state;
  logic [CNT_W-1:0] r_cnt, w_next_cnt;
  logic [3:0]       r_remaining, w_next_remaining;
  logic [4:0]       r_shadow, w_next_shadow;
  logic             r_clear, r_advance, r_busy, r_done, r_digit_err, r_check;
  logic             w_next_clear, w_next_advance, w_next_busy, w_next_done;
  logic             w_next_digit_err, w_next_check, w_accept;

`ifndef DECADE_EMITTER_CHECK_EN
  logic w_unused_count;
  assign w_unused_count = ^io_bus.i_count;
`endif

  // Next-state, phase counter and next values of every registered output.
  always_comb begin
    w_next_state     = r_state;
    w_next_cnt       = r_cnt + CNT_W'(1);
    w_next_remaining = r_remaining;
    w_next_digit_err = 1'b0;
    w_accept         = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_next_cnt = '0;
        if (io_bus.i_start) begin
          if (io_bus.i_digit <= 4'd9) begin
            w_accept         = 1'b1;
            w_next_remaining = io_bus.i_digit;
            w_next_state     = S_CLEAR;
          end else begin
            w_next_digit_err = 1'b1;
          end
        end
      end
      S_CLEAR: begin
        if (r_cnt == CNT_W'(CLR_W - 1)) begin
          w_next_cnt   = '0;
          w_next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        w_next_cnt   = '0;
        w_next_state = (r_remaining != 4'd0) ? S_PULSE : S_CHECK;
      end
      S_PULSE: begin
        if (r_cnt == CNT_W'(ADV_W - 1)) begin
          w_next_cnt       = '0;
          w_next_remaining = r_remaining - 4'd1;
          w_next_state     = S_GAP;
        end
      end
      S_GAP: begin
        if (r_cnt == CNT_W'(GAP - 1)) begin
          w_next_cnt   = '0;
          w_next_state = (r_remaining != 4'd0) ? S_PULSE : S_CHECK;
        end
      end
      S_CHECK: begin
        w_next_cnt   = '0;
        w_next_state = S_DONE;
      end
      S_DONE: begin
        w_next_cnt   = '0;
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_cnt   = '0;
        w_next_state = S_IDLE;
      end
    endcase

    // Strobes are decoded from the next state so they leave flops directly.
    w_next_clear   = (w_next_state == S_CLEAR);
    w_next_advance = (w_next_state == S_PULSE);
    w_next_busy    = (w_next_state != S_IDLE) && (w_next_state != S_DONE);
    w_next_done    = (w_next_state == S_DONE);

    // Shadow zeroes while clearing and takes one Johnson step per pulse.
    w_next_shadow = r_shadow;
    if (w_next_state == S_CLEAR)
      w_next_shadow = 5'b00000;
    else if ((w_next_state == S_PULSE) && (r_state != S_PULSE))
      w_next_shadow = {r_shadow[3:0], ~r_shadow[4]};

`ifdef DECADE_EMITTER_CHECK_EN
    w_next_check = r_check;
    if (w_accept)
      w_next_check = 1'b0;
    else if ((r_state == S_CHECK) && (io_bus.i_count != r_shadow))
      w_next_check = 1'b1;
`else
    w_next_check = 1'b0;
`endif
  end

  // State and output registers; reset drops every strobe on the same edge.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_remaining <= 4'd0;
      r_shadow    <= 5'b00000;
      r_clear     <= 1'b0;
      r_advance   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_digit_err <= 1'b0;
      r_check     <= 1'b0;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_remaining <= w_next_remaining;
      r_shadow    <= w_next_shadow;
      r_clear     <= w_next_clear;
      r_advance   <= w_next_advance;
      r_busy      <= w_next_busy;
      r_done      <= w_next_done;
      r_digit_err <= w_next_digit_err;
      r_check     <= w_next_check;
    end
  end

  assign io_bus.o_clear     = r_clear;
  assign io_bus.o_advance   = r_advance;
  assign io_bus.o_busy      = r_busy;
  assign io_bus.o_done      = r_done;
  assign io_bus.o_shadow    = r_shadow;
  assign io_bus.o_digit_err = r_digit_err;
  assign io_bus.o_check     = r_check;

endmodule
